pwm_sample_scheduler: RTL and testbench

Frame-synchronous sample feeder for the PWM audio DAC. Buffers decimated samples from the upstream demodulator/filter chain in a small FIFO with a valid/ready handshake. Owns the PWM frame timer and releases exactly one sample per PWM frame as an offset, saturated duty word. Handles startup priming, underrun and disable so the PWM comparator always sees a legal, stable duty value.

---
 rtl/pwm_sample_scheduler.sv | 165 ++++++++++++++++
 tb/tb_pwm_sample_scheduler.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_sample_scheduler.sv
// pwm_sample_scheduler: buffers signed samples in a small FWFT FIFO and
// releases one offset, saturated duty word per PWM frame.
module pwm_sample_scheduler #(
  parameter int unsigned DATA_WIDTH    = 12,
  parameter int unsigned COUNTER_WIDTH = 10,
  parameter int unsigned OFFSET        = 512,
  parameter int unsigned FIFO_AW       = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     Enable,
  input  logic [DATA_WIDTH-1:0]    DataIn,
  input  logic                     DataValid,
  output logic                     DataReady,
  output logic [COUNTER_WIDTH-1:0] Duty,
  output logic                     FrameStart,
  output logic [COUNTER_WIDTH-1:0] FrameCount,
  output logic                     Underrun,
  input  logic                     UnderrunClr,
  output logic [FIFO_AW:0]         Level
);

  localparam int unsigned DEPTH   = 1 << FIFO_AW;
  localparam int unsigned SUM_W   = DATA_WIDTH + 2;
  localparam int unsigned CNT_TOP = (1 << COUNTER_WIDTH) - 1;

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX     = COUNTER_WIDTH'(CNT_TOP);
  localparam logic [COUNTER_WIDTH-1:0] DUTY_MID    = COUNTER_WIDTH'(OFFSET);
  localparam logic [FIFO_AW:0]         LEVEL_FULL  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]         LEVEL_PRIME = (FIFO_AW + 1)'(DEPTH / 2);
  localparam logic [FIFO_AW:0]         LEVEL_ONE   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0]       PTR_ONE     = FIFO_AW'(1);
  localparam logic [SUM_W-1:0]         SUM_OFFSET  = SUM_W'(OFFSET);
  localparam logic [SUM_W-1:0]         SUM_TOP     = SUM_W'(CNT_TOP);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic [FIFO_AW-1:0]       wr_ptr;
  logic [FIFO_AW-1:0]       rd_ptr;
  logic [FIFO_AW:0]         level_next;
  logic                     full;
  logic                     empty;
  logic                     push;
  logic                     pop;
  logic                     frame_end;
  logic                     flush;
  logic [DATA_WIDTH-1:0]    head;
  logic [SUM_W-1:0]         sum;
  logic [COUNTER_WIDTH-1:0] duty_sat;

  // Handshake, frame boundary detection, occupancy update and head saturation
  always_comb begin
    full       = (Level == LEVEL_FULL);
    empty      = (Level == '0);
    DataReady  = (state != ST_IDLE) && !full;
    push       = DataValid && DataReady;
    frame_end  = (state == ST_RUN) && Enable && (FrameCount == CNT_MAX);
    pop        = frame_end && !empty;
    level_next = Level;
    if (push && !pop) begin
      level_next = Level + LEVEL_ONE;
    end else if (pop && !push) begin
      level_next = Level - LEVEL_ONE;
    end
    head = mem[rd_ptr];
    sum  = {{2{head[DATA_WIDTH-1]}}, head} + SUM_OFFSET;
    if (sum[SUM_W-1]) begin
      duty_sat = '0;
    end else if (sum > SUM_TOP) begin
      duty_sat = CNT_MAX;
    end else begin
      duty_sat = sum[COUNTER_WIDTH-1:0];
    end
  end

  // Next-state logic; priming completes on the edge the threshold is reached
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (Enable) state_next = ST_PRIME;
      end
      ST_PRIME: begin
        if (!Enable) begin
          state_next = ST_IDLE;
        end else if (level_next >= LEVEL_PRIME) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!Enable) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    flush = (state_next == ST_IDLE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FIFO pointers and occupancy; everything is dropped while idle
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      Level <= level_next;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= DataIn;
    end
  end

  // Frame timer and duty register; counter parks at max outside RUN
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      FrameCount <= CNT_MAX;
      Duty       <= DUTY_MID;
      FrameStart <= 1'b0;
    end else if (state == ST_RUN) begin
      FrameCount <= FrameCount + COUNTER_WIDTH'(1);
      FrameStart <= frame_end;
      if (frame_end) begin
        Duty <= empty ? DUTY_MID : duty_sat;
      end
    end else begin
      FrameCount <= CNT_MAX;
      Duty       <= DUTY_MID;
      FrameStart <= 1'b0;
    end
  end

  // Sticky underrun flag; a new underrun wins over a clear request
  always_ff @(posedge clk) begin
    if (rst) begin
      Underrun <= 1'b0;
    end else if (frame_end && empty) begin
      Underrun <= 1'b1;
    end else if (UnderrunClr) begin
      Underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_sample_scheduler.sv
// tb_pwm_sample_scheduler: directed tables, corner sequences and random
// traffic checked against a queue-based frame model.
module tb_pwm_sample_scheduler;

  localparam int DW = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        Enable;
  logic [11:0] DataIn;
  logic        DataValid;
  logic        DataReady;
  logic [9:0]  Duty;
  logic        FrameStart;
  logic [9:0]  FrameCount;
  logic        Underrun;
  logic        UnderrunClr;
  logic [3:0]  Level;

  int total = 0;
  int bad   = 0;

  pwm_sample_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .Enable     (Enable),
    .DataIn     (DataIn),
    .DataValid  (DataValid),
    .DataReady  (DataReady),
    .Duty       (Duty),
    .FrameStart (FrameStart),
    .FrameCount (FrameCount),
    .Underrun   (Underrun),
    .UnderrunClr(UnderrunClr),
    .Level      (Level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!FrameStart && n < limit);
    check("frame_seen", 32'(FrameStart), 32'(1));
  endtask

  function automatic int sat(input int s);
    int r;
    r = s + 512;
    if (r < 0) return 0;
    if (r > 1023) return 1023;
    return r;
  endfunction

  // Reference model: mode 0 idle, 1 priming, 2 running; samples kept in a queue
  int m_mode;
  int m_q[$];
  int m_cnt;
  int m_duty;
  bit m_fs;
  bit m_und;
  bit m_on = 1'b0;

  always @(posedge clk) begin
    bit rdy;
    bit pushed;
    bit set;
    if (rst) begin
      m_mode = 0;
      m_q.delete();
      m_cnt  = 1023;
      m_duty = 512;
      m_fs   = 1'b0;
      m_und  = 1'b0;
      m_on   = 1'b1;
    end else if (m_on) begin
      rdy    = (m_mode != 0) && (m_q.size() < 8);
      pushed = DataValid && rdy;
      set    = 1'b0;
      m_fs   = 1'b0;
      if (m_mode == 0) begin
        if (Enable) m_mode = 1;
      end else if (!Enable) begin
        m_mode = 0;
        m_q.delete();
        m_cnt  = 1023;
        m_duty = 512;
      end else begin
        if (m_mode == 2) begin
          if (m_cnt == 1023) begin
            m_fs  = 1'b1;
            m_cnt = 0;
            if (m_q.size() != 0) begin
              m_duty = sat(m_q.pop_front());
            end else begin
              m_duty = 512;
              set    = 1'b1;
            end
          end else begin
            m_cnt++;
          end
        end
        if (pushed) m_q.push_back(int'($signed(DataIn)));
        if (m_mode == 1 && m_q.size() >= 4) m_mode = 2;
      end
      if (set) m_und = 1'b1;
      else if (UnderrunClr) m_und = 1'b0;
    end
  end

  // Compare every output against the model away from the active edge
  always @(negedge clk) begin
    if (m_on) begin
      check("m_duty",  32'(Duty),       32'(m_duty));
      check("m_fs",    32'(FrameStart), 32'(m_fs));
      check("m_cnt",   32'(FrameCount), 32'(m_cnt));
      check("m_level", 32'(Level),      32'(m_q.size()));
      check("m_und",   32'(Underrun),   32'(m_und));
      check("m_ready", 32'(DataReady),  32'((m_mode != 0) && (m_q.size() < 8)));
    end
  end

  typedef struct {
    int sample;
    int duty;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int n;
    int rate;

    tbl[0] = '{0, 512};
    tbl[1] = '{-512, 0};
    tbl[2] = '{511, 1023};
    tbl[3] = '{100, 612};
    tbl[4] = '{-2048, 0};
    tbl[5] = '{2047, 1023};
    tbl[6] = '{-513, 0};
    tbl[7] = '{512, 1023};
    tbl[8] = '{-1, 511};
    tbl[9] = '{-300, 212};

    // Reset with Enable and DataValid held high
    rst = 1'b1; Enable = 1'b1; DataValid = 1'b1; DataIn = 12'h7FF; UnderrunClr = 1'b0;
    repeat (3) step();
    check("rst_duty",  32'(Duty),       32'(512));
    check("rst_level", 32'(Level),      32'(0));
    check("rst_ready", 32'(DataReady),  32'(0));
    check("rst_und",   32'(Underrun),   32'(0));
    check("rst_fs",    32'(FrameStart), 32'(0));
    check("rst_cnt",   32'(FrameCount), 32'(1023));

    rst = 1'b0; DataValid = 1'b0;
    step();
    check("prime_ready", 32'(DataReady),  32'(1));
    check("prime_cnt",   32'(FrameCount), 32'(1023));

    // Prime with the first four table samples
    for (int i = 0; i < 4; i++) begin
      DataIn = DW'(tbl[i].sample);
      DataValid = 1'b1;
      step();
    end
    check("primed_level", 32'(Level),      32'(4));
    check("primed_fs",    32'(FrameStart), 32'(0));

    fork
      begin
        for (int i = 4; i < 10; i++) begin
          int w;
          DataIn = DW'(tbl[i].sample);
          DataValid = 1'b1;
          w = 0;
          while (!DataReady && w < 3000) begin
            step();
            w++;
          end
          check("push_wait", 32'(w < 3000), 32'(1));
          step();
        end
        DataValid = 1'b0;
      end
      begin
        for (int i = 0; i < 10; i++) begin
          int k;
          wait_frame(1100, k);
          if (i == 0) check("first_latency", 32'(k), 32'(1));
          else        check("frame_spacing", 32'(k), 32'(1024));
          check("tbl_duty", 32'(Duty), 32'(tbl[i].duty));
          check("tbl_cnt",  32'(FrameCount), 32'(0));
        end
      end
    join

    // Underrun once the table has drained
    wait_frame(1100, n);
    check("und_spacing", 32'(n), 32'(1024));
    check("und_duty",    32'(Duty), 32'(512));
    check("und_flag",    32'(Underrun), 32'(1));
    repeat (5) step();
    check("und_sticky", 32'(Underrun), 32'(1));
    UnderrunClr = 1'b1;
    step();
    UnderrunClr = 1'b0;
    check("und_clr", 32'(Underrun), 32'(0));
    n = 0;
    while (FrameCount != 10'd1023 && n < 1100) begin
      step();
      n++;
    end
    check("reach_max", 32'(FrameCount), 32'(1023));
    UnderrunClr = 1'b1;
    step();
    UnderrunClr = 1'b0;
    check("set_over_clr",    32'(Underrun),   32'(1));
    check("set_over_clr_fs", 32'(FrameStart), 32'(1));

    // Fill to full while running
    for (int k = 1; k <= 8; k++) begin
      DataIn = DW'(k * 10);
      DataValid = 1'b1;
      step();
    end
    check("full_level", 32'(Level),     32'(8));
    check("full_ready", 32'(DataReady), 32'(0));
    DataIn = DW'(999);
    repeat (3) step();
    check("full_hold", 32'(Level), 32'(8));
    wait_frame(1100, n);
    check("full_pop_level", 32'(Level), 32'(7));
    check("full_pop_duty",  32'(Duty),  32'(522));
    step();
    check("full_refill", 32'(Level), 32'(8));
    DataValid = 1'b0;

    // Disable flushes; Underrun survives
    Enable = 1'b0;
    step();
    check("dis_level", 32'(Level),    32'(0));
    check("dis_und",   32'(Underrun), 32'(1));
    Enable = 1'b1;
    step();
    DataIn = DW'(300);
    DataValid = 1'b1;
    repeat (4) step();
    DataValid = 1'b0;
    wait_frame(10, n);
    check("re_latency", 32'(n),     32'(1));
    check("re_duty",    32'(Duty),  32'(812));
    check("re_level",   32'(Level), 32'(3));
    DataValid = 1'b1;
    repeat (2) step();
    DataValid = 1'b0;
    repeat (10) step();
    check("mid_level", 32'(Level), 32'(5));
    check("mid_duty",  32'(Duty),  32'(812));
    Enable = 1'b0;
    step();
    check("mid_dis_level", 32'(Level),      32'(0));
    check("mid_dis_duty",  32'(Duty),       32'(512));
    check("mid_dis_fs",    32'(FrameStart), 32'(0));
    check("mid_dis_ready", 32'(DataReady),  32'(0));
    check("mid_dis_cnt",   32'(FrameCount), 32'(1023));
    repeat (3) step();
    check("idle_fs", 32'(FrameStart), 32'(0));

    // Re-enable runs a full priming sequence
    Enable = 1'b1;
    step();
    check("re2_ready", 32'(DataReady),  32'(1));
    check("re2_level", 32'(Level),      32'(0));
    check("re2_cnt",   32'(FrameCount), 32'(1023));
    DataIn = DW'(-100);
    DataValid = 1'b1;
    repeat (4) step();
    DataValid = 1'b0;
    wait_frame(10, n);
    check("re2_latency", 32'(n),    32'(1));
    check("re2_duty",    32'(Duty), 32'(412));

    // Reset mid-operation with Enable still high
    DataIn = DW'(5);
    DataValid = 1'b1;
    repeat (2) step();
    rst = 1'b1;
    step();
    check("mrst_duty",  32'(Duty),       32'(512));
    check("mrst_level", 32'(Level),      32'(0));
    check("mrst_und",   32'(Underrun),   32'(0));
    check("mrst_cnt",   32'(FrameCount), 32'(1023));
    check("mrst_ready", 32'(DataReady),  32'(0));
    check("mrst_fs",    32'(FrameStart), 32'(0));
    rst = 1'b0;
    DataValid = 1'b0;

    // Random traffic with varying feed rates
    rate = 2;
    for (int c = 0; c < 20000; c++) begin
      if (c % 2048 == 0) begin
        case ((c / 2048) % 3)
          0:       rate = 2;
          1:       rate = 300;
          default: rate = 1500;
        endcase
      end
      Enable      = ($urandom_range(0, 3999) != 0);
      DataValid   = ($urandom_range(0, rate - 1) == 0);
      DataIn      = DW'($urandom);
      UnderrunClr = ($urandom_range(0, 699) == 0);
      rst         = ($urandom_range(0, 9999) == 0);
      step();
    end
    rst = 1'b0;
    DataValid = 1'b0;
    UnderrunClr = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
